wb_counter_7seg_mux: RTL and testbench
======================================

Name: wb_counter_7seg_mux

Overview:
- Next-generation counter peripheral for the user project area: a Wishbone-controlled up/down counter with a prescaler and a programmable terminal value.
- Drives the counter value onto GPIOs in binary.
- Drives all hex digits of the count onto a time-multiplexed 7-segment display, using shared segment lines plus per-digit select lines.
- Raises an interrupt on wrap. Sits directly under the user wrapper, which maps its outputs onto GPIO slices and user_irq[0].

Parameters:
- BITS, 16: counter width (4..32).
- DIGITS, 4: number of multiplexed hex digits (1..8). Nibble i shows count[4i+3:4i]. Bits at or above BITS read as 0.
- SCAN_DIV_W, 10: width of the free-running scan divider. The display advances one digit every 2^SCAN_DIV_W clocks.
- BASE_ADDR, 32'h3000_0000: Wishbone base address. The block decodes a 16-byte window.

Ports:
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset; asserts asynchronously and is released synchronously by the wrapper.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- count_out  out  BITS  counter value.
- count_oeb  out  BITS  output-enable bar for count_out.
- seg_out  out  7  segments a..g, mapped to bits 0..6.
- seg_oeb  out  7  output-enable bar for seg_out.
- digit_sel_out  out  DIGITS  one-hot digit select.
- digit_sel_oeb  out  DIGITS  output-enable bar for digit_sel_out.
- irq  out  1  level interrupt.

Behaviour:

Register map (word offset = adr[3:2]). Writes honour wbs_sel_i.
- 0 CTRL (reset value 0):
  - b0 EN: count enable.
  - b1 DOWN: count direction.
  - b2 IRQ_EN.
  - b3 INV: active-low display; inverts seg_out and digit_sel_out.
  - b4 OE: output enable.
  - b8 WRAP: sticky status; write 1 to clear.
- 1 PRESCALE[15:0] (reset 0): the counter steps once per PRESCALE+1 clocks.
- 2 COUNT: a read returns the live count. A write loads the count.
- 3 TERM (reset all-ones, BITS wide): terminal value.

Wishbone handshake:
- A request matches when cyc & stb & (adr[31:4]==BASE_ADDR[31:4]).
- ack is registered. It rises one clock after the request and is held for exactly one clock.
- ack is never asserted on two consecutive clocks.
- Writes commit on the same clock edge that raises ack.
- wbs_dat_o carries read data while ack=1, and is 0 otherwise.
- Non-matching addresses get no ack and no side effect.
- Unused read bits return 0.

Prescaler:
- Counts from 0 up to PRESCALE while EN=1, then emits a one-clock tick and restarts at 0.
- It is cleared when EN=0 and on any PRESCALE write.

Counting on a tick:
- Up: if count==TERM, count goes to 0 and WRAP is set. Otherwise count increments by 1.
- Down: if count==0, count goes to TERM and WRAP is set. Otherwise count decrements by 1.
- If count>TERM while counting up, the count keeps incrementing and wraps to 0 naturally at 2^BITS; that natural wrap sets WRAP.

Simultaneous events:
- A COUNT write in the same clock as a tick: the load wins, the tick is discarded, and the prescaler restarts.
- A WRAP set and a W1C write in the same clock: the set wins.

Interrupt: irq = WRAP & IRQ_EN, driven combinationally from registers.

Display scan:
- The scan divider runs free whenever the block is out of reset.
- On divider wrap, the digit index advances: 0, 1, …, DIGITS-1, then back to 0.
- digit_sel_out = OE ? ((1<<idx) ^ {DIGITS{INV}}) : 0.
- seg_out = OE ? (hex7(nibble[idx]) ^ {7{INV}}) : 0.
- hex7 covers 0-F; for example, 0 = 7'h3F, 4 = 7'h66, 8 = 7'h7F, A = 7'h77.
- seg_out and digit_sel_out are registered, one clock after idx changes.

Output enables:
- count_out is driven as count.
- Every *_oeb bit equals ~OE; outputs are high-impedance after reset.

Reset (asynchronous, any time, including mid-transaction):
- Outputs: wbs_ack_o=0, wbs_dat_o=0, count_out=0, seg_out=0, digit_sel_out=0, all oeb bits=1, irq=0.
- Internal state: idx=0, prescaler=0, scan divider=0.
- Any in-flight Wishbone request is dropped without ack.

Decomposition:
- Package wb_counter_pkg holds:
  - register offsets;
  - CTRL bit indices;
  - the 16-entry hex7 constant table;
  - the hex7 function.
- Sub-module seg7_scan handles the scan divider, index register, nibble mux and registered segment/select outputs. Its parameters are BITS, DIGITS and SCAN_DIV_W.
- The top level keeps the Wishbone slave, control registers, prescaler and counter.

Test Plan:
1. Handshake: write CTRL=0x11, then read it back → each ack lasts one clock, starting one clock after stb; readback is 0x11. An access at BASE_ADDR+0x40 → no ack within 8 clocks.
2. Prescaled counting: PRESCALE=3, TERM=9, CTRL=0x15 → count steps every 4 clocks; 9 is followed by 0; WRAP=1 and irq=1. Writing 0x100 to CTRL clears irq.
3. Down count: load 0, TERM=9, CTRL=0x13 → the first tick yields 9 and sets WRAP. Load 5 in the same clock as a tick → count=5, and the next step comes 4 clocks later.
4. Scan: SCAN_DIV_W=2, count=0x1234, OE=1, INV=0 → digit_sel walks 0001, 0010, 0100, 1000, one digit every 4 clocks. seg shows 0x66, 0x4F, 0x5B, 0x06 (digits 4, 3, 2, 1). With INV=1, both buses are inverted.
5. Reset mid-operation: assert wb_rst_n low while counting and with an ack pending → all outputs take their reset values immediately (asynchronously); after release, count=0 and no stale ack appears.

Source files
------------

// File: rtl/wb_counter_pkg.sv
// Shared register map, CTRL layout and 7-segment decode for the Wishbone
// counter / multiplexed hex display peripheral.
package wb_counter_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_COUNT    = 2'd2;
  localparam logic [1:0] REG_TERM     = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_DOWN   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_INV    = 3;
  localparam int CTRL_OE     = 4;
  localparam int CTRL_WRAP   = 8;

  typedef struct packed {
    logic wrap;
    logic oe;
    logic inv;
    logic irq_en;
    logic down;
    logic en;
  } ctrl_t;

  // Segments a..g on bits 0..6; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return HEX7_TABLE[nib];
  endfunction

endpackage

// File: rtl/wb_counter_7seg_mux_seg7_scan.sv
// Display scanner: free-running divider steps the digit index, and the
// selected nibble is decoded into registered segment / digit-select buses.
module seg7_scan
  import wb_counter_pkg::*;
#(
  parameter int BITS       = 16,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS-1:0]   count,
  input  logic              oe,
  input  logic              inv,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_sel
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PAD_W = (4 * DIGITS > BITS) ? 4 * DIGITS : BITS;

  logic [SCAN_DIV_W-1:0] div;
  logic [IDX_W-1:0]      idx;
  logic [PAD_W-1:0]      count_pad;
  logic [3:0]            nibble;
  logic [DIGITS-1:0]     onehot;
  logic                  unused_pad;

  // Digits past the counter width read as zero.
  assign count_pad  = PAD_W'(count);
  assign nibble     = count_pad[{idx, 2'b00} +: 4];
  assign onehot     = DIGITS'(1) << idx;
  assign unused_pad = &{1'b0, count_pad};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else begin
      div <= div + 1'b1;
      if (&div) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg       <= '0;
      digit_sel <= '0;
    end else begin
      seg       <= oe ? (hex7(nibble) ^ {7{inv}}) : '0;
      digit_sel <= oe ? (onehot ^ {DIGITS{inv}}) : '0;
    end
  end

endmodule

// File: rtl/wb_counter_7seg_mux.sv
// Wishbone up/down counter with prescaler, terminal value, wrap interrupt,
// binary GPIO output and a time-multiplexed hex display.
module wb_counter_7seg_mux
  import wb_counter_pkg::*;
#(
  parameter int          BITS       = 16,
  parameter int          DIGITS     = 4,
  parameter int          SCAN_DIV_W = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [BITS-1:0]   count_out,
  output logic [BITS-1:0]   count_oeb,
  output logic [6:0]        seg_out,
  output logic [6:0]        seg_oeb,
  output logic [DIGITS-1:0] digit_sel_out,
  output logic [DIGITS-1:0] digit_sel_oeb,
  output logic              irq
);
  ctrl_t           ctrl;
  logic [15:0]     prescale, psc;
  logic [BITS-1:0] count, term, count_nxt, wmask_b, wdata_b;
  logic [31:0]     wmask, rdata;
  logic [1:0]      off;
  logic            req, acc, wr, rd;
  logic            ctrl_wr, psc_wr, cnt_wr, term_wr;
  logic            tick, wrap_evt;
  logic            unused_ok;

  assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // Blocking on the current ack keeps acks one clock wide and never back to back.
  assign acc     = req & ~wbs_ack_o;
  assign wr      = acc & wbs_we_i;
  assign rd      = acc & ~wbs_we_i;
  assign off     = wbs_adr_i[3:2];
  assign ctrl_wr = wr & (off == REG_CTRL);
  assign psc_wr  = wr & (off == REG_PRESCALE);
  assign cnt_wr  = wr & (off == REG_COUNT);
  assign term_wr = wr & (off == REG_TERM);

  assign wmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmask_b = wmask[BITS-1:0];
  assign wdata_b = wbs_dat_i[BITS-1:0];
  assign unused_ok = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, wmask};

  assign tick = ctrl.en & (psc == prescale);

  always_comb begin
    count_nxt = count;
    wrap_evt  = 1'b0;
    if (cnt_wr) begin
      count_nxt = (count & ~wmask_b) | (wdata_b & wmask_b);
    end else if (tick) begin
      if (ctrl.down) begin
        wrap_evt  = (count == '0);
        count_nxt = wrap_evt ? term : count - 1'b1;
      end else begin
        // Above TERM the count runs on and wraps naturally at all-ones.
        wrap_evt  = (count == term) | (&count);
        count_nxt = (count == term) ? '0 : count + 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL: begin
        rdata[CTRL_EN]     = ctrl.en;
        rdata[CTRL_DOWN]   = ctrl.down;
        rdata[CTRL_IRQ_EN] = ctrl.irq_en;
        rdata[CTRL_INV]    = ctrl.inv;
        rdata[CTRL_OE]     = ctrl.oe;
        rdata[CTRL_WRAP]   = ctrl.wrap;
      end
      REG_PRESCALE: rdata[15:0]     = prescale;
      REG_COUNT:    rdata[BITS-1:0] = count;
      REG_TERM:     rdata[BITS-1:0] = term;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rdata : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ctrl <= '0;
    end else begin
      if (ctrl_wr && wbs_sel_i[0]) begin
        ctrl.en     <= wbs_dat_i[CTRL_EN];
        ctrl.down   <= wbs_dat_i[CTRL_DOWN];
        ctrl.irq_en <= wbs_dat_i[CTRL_IRQ_EN];
        ctrl.inv    <= wbs_dat_i[CTRL_INV];
        ctrl.oe     <= wbs_dat_i[CTRL_OE];
      end
      // A wrap in the same clock as the clearing write stays set.
      if (wrap_evt)
        ctrl.wrap <= 1'b1;
      else if (ctrl_wr && wbs_sel_i[1] && wbs_dat_i[CTRL_WRAP])
        ctrl.wrap <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      prescale <= '0;
      term     <= '1;
      count    <= '0;
      psc      <= '0;
    end else begin
      if (psc_wr) prescale <= (prescale & ~wmask[15:0]) | (wbs_dat_i[15:0] & wmask[15:0]);
      if (term_wr) term <= (term & ~wmask_b) | (wdata_b & wmask_b);
      count <= count_nxt;
      if (!ctrl.en || psc_wr || cnt_wr || tick) psc <= '0;
      else psc <= psc + 16'd1;
    end
  end

  assign count_out     = count;
  assign count_oeb     = {BITS{~ctrl.oe}};
  assign seg_oeb       = {7{~ctrl.oe}};
  assign digit_sel_oeb = {DIGITS{~ctrl.oe}};
  assign irq           = ctrl.wrap & ctrl.irq_en;

  seg7_scan #(
    .BITS       (BITS),
    .DIGITS     (DIGITS),
    .SCAN_DIV_W (SCAN_DIV_W)
  ) u_scan (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n),
    .count     (count),
    .oe        (ctrl.oe),
    .inv       (ctrl.inv),
    .seg       (seg_out),
    .digit_sel (digit_sel_out)
  );

endmodule

// File: tb/tb_wb_counter_7seg_mux.sv
// Scoreboarded bench for wb_counter_7seg_mux: bus accesses queue their
// expected response, a negedge monitor pops on every ack.
module tb_wb_counter_7seg_mux;
  localparam int          BITS   = 16;
  localparam int          DIGITS = 4;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic              clk = 1'b0, rst_n = 1'b1;
  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]        sel = 4'h0;
  logic [31:0]       adr = '0, dat_w = '0;
  logic              ack;
  logic [31:0]       dat_r;
  logic [BITS-1:0]   count_out, count_oeb;
  logic [6:0]        seg, seg_oeb;
  logic [DIGITS-1:0] dsel, dsel_oeb;
  logic              irq;

  typedef struct { bit chk; logic [31:0] data; string name; } exp_t;
  exp_t sb[$];
  int   total = 0, bad = 0;
  logic prev_ack = 1'b0;

  always #5 clk = ~clk;

  wb_counter_7seg_mux #(.BITS(BITS), .DIGITS(DIGITS), .SCAN_DIV_W(2), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .count_out(count_out), .count_oeb(count_oeb), .seg_out(seg), .seg_oeb(seg_oeb),
    .digit_sel_out(dsel), .digit_sel_oeb(dsel_oeb), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!ack) check("dat_idle", dat_r, 32'h0);
      else begin
        check("ack_back2back", {31'b0, prev_ack}, 32'h0);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL ack_unexpected: got ack with empty scoreboard, want none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.chk && dat_r !== e.data) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, dat_r, e.data);
          end
        end
      end
    end
    prev_ack <= ack;
  end

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit chk, input logic [31:0] exp, input string name);
    int lat;
    exp_t e;
    e.chk = chk; e.data = exp; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack && lat < 8);
    check({name, "_latency"}, lat, 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] o, input logic [31:0] d, input string name);
    bus(1'b1, BASE + {28'h0, o, 2'b00}, d, 4'hF, 1'b0, 32'h0, name);
  endtask

  task automatic rd(input logic [1:0] o, input logic [31:0] exp, input string name);
    bus(1'b0, BASE + {28'h0, o, 2'b00}, 32'h0, 4'hF, 1'b1, exp, name);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, {31'b0, ack}, 32'h0);
    check({tag, "_dat"}, dat_r, 32'h0);
    check({tag, "_count"}, 32'(count_out), 32'h0);
    check({tag, "_seg"}, 32'(seg), 32'h0);
    check({tag, "_dsel"}, 32'(dsel), 32'h0);
    check({tag, "_oeb"}, {9'b0, count_oeb, seg_oeb}, {9'b0, 16'hFFFF, 7'h7F});
    check({tag, "_dsel_oeb"}, 32'(dsel_oeb), 32'hF);
    check({tag, "_irq"}, {31'b0, irq}, 32'h0);
  endtask

  // Syncs to the last-digit -> first-digit transition, then walks all digits.
  task automatic scan_pass(input logic [3:0][3:0] esel, input logic [3:0][6:0] eseg, input string tag);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = dsel;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev == esel[3] && dsel == esel[0]) found = 1'b1;
      prev = dsel;
    end
    check({tag, "_sync"}, {31'b0, found}, 32'h1);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) begin
        step(3);
        check({tag, "_hold"}, 32'(dsel), 32'(esel[d-1]));
        step(1);
      end
      check({tag, "_sel"}, 32'(dsel), 32'(esel[d]));
      check({tag, "_seg"}, 32'(seg), 32'(eseg[d]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    step(3);
    rst_n = 1'b1;
    rd(2'd0, 32'h0, "rst_ctrl");
    rd(2'd1, 32'h0, "rst_prescale");
    rd(2'd2, 32'h0, "rst_count");
    rd(2'd3, 32'h0000_FFFF, "rst_term");

    // Handshake, readback, out-of-window access with no side effect.
    wr(2'd0, 32'h11, "w_ctrl");
    rd(2'd0, 32'h11, "rb_ctrl");
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h40; dat_w = 32'hFF; sel = 4'hF;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack) n++;
    end
    check("noack_far", n, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rd(2'd0, 32'h11, "far_no_effect");

    // Prescaled up count with wrap at TERM.
    wr(2'd0, 32'h0, "stop");
    wr(2'd1, 32'd3, "w_psc");
    wr(2'd3, 32'd9, "w_term");
    wr(2'd2, 32'd7, "w_count");
    wr(2'd0, 32'h15, "w_ctrl_up");
    step(3); check("up_m3", 32'(count_out), 7);
    step(1); check("up_m4", 32'(count_out), 8);
    step(3); check("up_m7", 32'(count_out), 8);
    step(1); check("up_m8", 32'(count_out), 9);
    step(3); check("up_m11", 32'(count_out), 9);
             check("irq_before_wrap", {31'b0, irq}, 0);
    step(1); check("up_wrap", 32'(count_out), 0);
             check("irq_after_wrap", {31'b0, irq}, 1);
    rd(2'd0, 32'h115, "ctrl_wrap_set");
    wr(2'd0, 32'h100, "w1c_wrap");
    check("irq_cleared", {31'b0, irq}, 0);
    rd(2'd0, 32'h0, "ctrl_wrap_clr");

    // Down count, underflow to TERM, load colliding with a tick.
    wr(2'd2, 32'd0, "w_count0");
    wr(2'd1, 32'd3, "w_psc2");
    wr(2'd0, 32'h13, "w_ctrl_down");
    step(3); check("dn_m3", 32'(count_out), 0);
    step(1); check("dn_underflow", 32'(count_out), 9);
    step(2);
    wr(2'd2, 32'd5, "w_load_on_tick");
    check("load_wins", 32'(count_out), 5);
    step(3); check("load_hold", 32'(count_out), 5);
    step(1); check("load_next_step", 32'(count_out), 4);
    rd(2'd0, 32'h113, "ctrl_down_wrap");
    wr(2'd0, 32'h100, "w1c_wrap2");

    // Byte-lane write: only byte 1 of TERM changes.
    bus(1'b1, BASE + 32'hC, 32'h0000_1234, 4'b0010, 1'b0, 32'h0, "w_term_sel");
    rd(2'd3, 32'h1209, "term_sel");

    // Display scan, normal then inverted, then outputs disabled.
    wr(2'd2, 32'h1234, "w_count_scan");
    wr(2'd0, 32'h10, "w_ctrl_oe");
    check("count_out_scan", {count_oeb, count_out}, {16'h0000, 16'h1234});
    scan_pass({4'b1000, 4'b0100, 4'b0010, 4'b0001}, {7'h06, 7'h5B, 7'h4F, 7'h66}, "scan");
    wr(2'd2, 32'hA8F0, "w_count_inv");
    wr(2'd0, 32'h18, "w_ctrl_inv");
    scan_pass({4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h08, 7'h00, 7'h0E, 7'h40}, "scan_inv");
    wr(2'd0, 32'h08, "w_ctrl_noe");
    step(2);
    check("noe_bus", {7'b0, seg_oeb, dsel_oeb, 7'b0, seg, dsel}, {7'b0, 7'h7F, 4'hF, 7'b0, 7'h00, 4'h0});
    check("noe_count_oeb", 32'(count_oeb), 32'hFFFF);

    // Asynchronous reset while counting, with an ack on the bus.
    wr(2'd1, 32'd0, "w_psc0");
    wr(2'd2, 32'h100, "w_count_run");
    wr(2'd0, 32'h15, "w_ctrl_run");
    step(3);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    @(posedge clk);
    #1 check("pre_rst_ack", {31'b0, ack}, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    cyc = 1'b0; stb = 1'b0;
    step(3);
    check("rst_hold_count", 32'(count_out), 0);
    rst_n = 1'b1;
    step(4);
    check("post_rst_count", 32'(count_out), 0);
    rd(2'd2, 32'h0, "post_rst_rd_count");
    rd(2'd0, 32'h0, "post_rst_rd_ctrl");
    rd(2'd3, 32'h0000_FFFF, "post_rst_rd_term");
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
